// File: rtl/oled_wr_if.sv
// Word-wide write port into the OLED sequencer: text buffer lanes plus the control register.
interface oled_wr_if #(
  parameter int ADDR_W = 8
);
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [31:0]       WR_DATA;
  logic [3:0]        WR_BE;
  logic              WR_ACK;

  modport master (output WR_EN, output WR_ADDR, output WR_DATA, output WR_BE, input WR_ACK);
  modport slave  (input WR_EN, input WR_ADDR, input WR_DATA, input WR_BE, output WR_ACK);
endinterface

// File: rtl/oled_seq_ctrl.sv
// PmodOLED sequencer: text buffer, init/clear/update FSM driving external engines, SPI pin mux.
module oled_seq_ctrl #(
  parameter int         NUM_CHARS   = 64,
  parameter int         ADDR_W      = 8,
  parameter int         CTRL_ADDR   = 2**ADDR_W-1,
  parameter int         TIMEOUT_CYC = 50_000_000,
  parameter int         REFRESH_CYC = 5_000_000,
  parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
  input  logic                   CLK,
  input  logic                   RST,
  oled_wr_if.slave               wr,
  output logic [7:0]             STATUS,
  output logic                   INIT_EN,
  input  logic                   INIT_DONE,
  input  logic                   INIT_CS,
  input  logic                   INIT_SDO,
  input  logic                   INIT_SCLK,
  input  logic                   INIT_DC,
  output logic                   DRAW_EN,
  output logic                   DRAW_CLEAR,
  output logic                   DRAW_MODE,
  input  logic                   DRAW_DONE,
  input  logic                   DRAW_CS,
  input  logic                   DRAW_SDO,
  input  logic                   DRAW_SCLK,
  input  logic                   DRAW_DC,
  output logic [NUM_CHARS*8-1:0] CHAR_BUF,
  output logic                   CS,
  output logic                   SDIN,
  output logic                   SCLK,
  output logic                   DC,
  output logic                   LED_INIT,
  output logic                   LED_READY
);
  localparam int                NUM_WORDS = NUM_CHARS / 4;
  localparam logic [ADDR_W-1:0] WORDS_A   = ADDR_W'(NUM_WORDS);
  localparam logic [ADDR_W-1:0] CTRL_A    = ADDR_W'(CTRL_ADDR);
  localparam logic [31:0]       TMO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0]       REF_LAST  = 32'(REFRESH_CYC - 1);

  typedef enum logic [2:0] {S_START, S_INIT, S_CLEAR, S_UPDATE, S_WAIT, S_IDLE, S_ERROR} state_t;

  state_t                 state_q, state_d;
  logic [NUM_CHARS*8-1:0] buf_q, buf_d, snap_q, snap_d;
  logic                   dirty_q, dirty_d, upd_q, upd_d, clr_q, clr_d, reinit_q, reinit_d;
  logic                   mode_q, mode_d, auto_q, auto_d, addr_err_q, addr_err_d, err_q, err_d;
  logic                   tick_q, tick_d, led_init_q, led_init_d, wr_ack_q, wr_ack_d;
  logic                   init_en_q, init_en_d, draw_en_q, draw_en_d;
  logic                   draw_clr_q, draw_clr_d, draw_mode_q, draw_mode_d;
  logic [31:0]            tmo_q, tmo_d, ref_q, ref_d;
  logic                   tmo_hit, enter_upd;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    snap_d     = snap_q;
    dirty_d    = dirty_q;
    upd_d      = upd_q;
    clr_d      = clr_q;
    reinit_d   = reinit_q;
    mode_d     = mode_q;
    auto_d     = auto_q;
    addr_err_d = addr_err_q;
    err_d      = err_q;
    tick_d     = tick_q;
    led_init_d = led_init_q;
    ref_d      = '0;
    tmo_hit    = (TIMEOUT_CYC != 0) && (tmo_q == TMO_LAST);

    case (state_q)
      S_START:  state_d = S_INIT;
      S_INIT:   if (INIT_DONE) state_d = S_CLEAR; else if (tmo_hit) state_d = S_ERROR;
      S_CLEAR: begin
        if (DRAW_DONE) begin
          state_d = S_WAIT;
          clr_d   = 1'b0;
          buf_d   = {NUM_CHARS{BLANK_CHAR}};
        end else if (tmo_hit) begin
          state_d = S_ERROR;
        end
      end
      S_UPDATE: if (DRAW_DONE) state_d = S_WAIT; else if (tmo_hit) state_d = S_ERROR;
      S_WAIT:   if (!DRAW_DONE) state_d = S_IDLE;
      S_IDLE: begin
        if (reinit_q)                        state_d = S_START;
        else if (clr_q)                      state_d = S_CLEAR;
        else if (upd_q)                      state_d = S_UPDATE;
        else if (auto_q && tick_q && dirty_q) state_d = S_UPDATE;
      end
      S_ERROR:  if (reinit_q) state_d = S_START;
      default:  state_d = S_START;
    endcase

    if (state_d == S_START && state_q != S_START) begin
      reinit_d = 1'b0;
      err_d    = 1'b0;
    end
    if (state_d == S_ERROR) err_d = 1'b1;
    if (state_d == S_IDLE)  led_init_d = 1'b1;

    // Snapshot takes the pre-write buffer; a same-cycle write re-marks dirty below.
    enter_upd = (state_d == S_UPDATE) && (state_q != S_UPDATE);
    if (enter_upd) begin
      snap_d  = buf_q;
      dirty_d = 1'b0;
      upd_d   = 1'b0;
      tick_d  = 1'b0;
    end

    if (auto_q) begin
      if (ref_q == REF_LAST) tick_d = 1'b1;
      else                   ref_d  = ref_q + 32'd1;
    end

    // New requests are applied last so they survive a same-cycle clear of the flag.
    if (wr.WR_EN) begin
      if (wr.WR_ADDR < WORDS_A) begin
        for (int k = 0; k < 4; k++) begin
          if (wr.WR_BE[k]) begin
            buf_d[(int'(wr.WR_ADDR) * 4 + k) * 8 +: 8] = wr.WR_DATA[k*8 +: 8];
            dirty_d = 1'b1;
          end
        end
      end else if (wr.WR_ADDR == CTRL_A) begin
        if (wr.WR_DATA[0]) upd_d    = 1'b1;
        if (wr.WR_DATA[1]) clr_d    = 1'b1;
        if (wr.WR_DATA[4]) reinit_d = 1'b1;
        mode_d = wr.WR_DATA[2];
        auto_d = wr.WR_DATA[3];
      end else begin
        addr_err_d = 1'b1;
      end
    end

    if (state_d != state_q)
      tmo_d = '0;
    else if (state_q == S_INIT || state_q == S_CLEAR || state_q == S_UPDATE)
      tmo_d = tmo_q + 32'd1;
    else
      tmo_d = '0;

    wr_ack_d    = wr.WR_EN;
    init_en_d   = (state_d == S_INIT);
    draw_en_d   = (state_d == S_CLEAR) || (state_d == S_UPDATE);
    draw_clr_d  = (state_d == S_CLEAR);
    draw_mode_d = enter_upd ? mode_q : ((state_d == S_UPDATE) ? draw_mode_q : 1'b0);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_START;
      buf_q       <= {NUM_CHARS{BLANK_CHAR}};
      snap_q      <= {NUM_CHARS{BLANK_CHAR}};
      dirty_q     <= 1'b0;
      upd_q       <= 1'b0;
      clr_q       <= 1'b0;
      reinit_q    <= 1'b0;
      mode_q      <= 1'b0;
      auto_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      err_q       <= 1'b0;
      tick_q      <= 1'b0;
      led_init_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      init_en_q   <= 1'b0;
      draw_en_q   <= 1'b0;
      draw_clr_q  <= 1'b0;
      draw_mode_q <= 1'b0;
      tmo_q       <= '0;
      ref_q       <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      snap_q      <= snap_d;
      dirty_q     <= dirty_d;
      upd_q       <= upd_d;
      clr_q       <= clr_d;
      reinit_q    <= reinit_d;
      mode_q      <= mode_d;
      auto_q      <= auto_d;
      addr_err_q  <= addr_err_d;
      err_q       <= err_d;
      tick_q      <= tick_d;
      led_init_q  <= led_init_d;
      wr_ack_q    <= wr_ack_d;
      init_en_q   <= init_en_d;
      draw_en_q   <= draw_en_d;
      draw_clr_q  <= draw_clr_d;
      draw_mode_q <= draw_mode_d;
      tmo_q       <= tmo_d;
      ref_q       <= ref_d;
    end
  end

  // SPI is passed through combinationally so engine timing reaches the pins unchanged.
  always_comb begin
    CS   = 1'b1;
    SCLK = 1'b1;
    SDIN = 1'b0;
    DC   = 1'b0;
    case (state_q)
      S_INIT: begin
        CS = INIT_CS; SCLK = INIT_SCLK; SDIN = INIT_SDO; DC = INIT_DC;
      end
      S_CLEAR, S_UPDATE: begin
        CS = DRAW_CS; SCLK = DRAW_SCLK; SDIN = DRAW_SDO; DC = DRAW_DC;
      end
      default: ;
    endcase
  end

  assign wr.WR_ACK  = wr_ack_q;
  assign INIT_EN    = init_en_q;
  assign DRAW_EN    = draw_en_q;
  assign DRAW_CLEAR = draw_clr_q;
  assign DRAW_MODE  = draw_mode_q;
  assign CHAR_BUF   = snap_q;
  assign LED_INIT   = led_init_q;
  assign LED_READY  = (state_q == S_IDLE);
  assign STATUS     = {err_q, addr_err_q, dirty_q, upd_q, clr_q, mode_q, auto_q, (state_q == S_IDLE)};
endmodule
